// File: rtl/m_imem_loader_pkg.sv
// Shared types and constants for the serial instruction-memory loader.
// Frame layout: LEN_HI, LEN_LO, N*4 data bytes (big-endian words), SUM.
package m_imem_loader_pkg;

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_SUM,
    S_DONE,
    S_ERR
  } state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam int DEF_CLKS_PER_BIT   = 434;
  localparam int DEF_TIMEOUT_CYCLES = 5000000;
  localparam int DEF_ADDR_W         = 12;

  // Byte offsets of the frame fields; SUM sits at POS_DATA + WORD_BYTES*N.
  localparam int POS_LEN_HI = 0;
  localparam int POS_LEN_LO = 1;
  localparam int POS_DATA   = 2;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/m_imem_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, half-bit start re-check, centre sampling.
// Emits a one-cycle byte-valid pulse on a good stop bit, a framing-error pulse otherwise.
module m_uart_rx
  import m_imem_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       w_clk,
  input  logic       w_rst,
  input  logic       w_rxd,
  output logic [7:0] r_byte,
  output logic       r_byte_valid,
  output logic       r_frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_t        state, state_n;
  logic             rxd_meta, rxd_sync;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shift, shift_n;
  logic             byte_valid_n, frame_err_n;

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      rxd_meta     <= 1'b1;
      rxd_sync     <= 1'b1;
      state        <= RX_IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      r_byte       <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      rxd_meta     <= w_rxd;
      rxd_sync     <= rxd_meta;
      state        <= state_n;
      cnt          <= cnt_n;
      bit_idx      <= bit_idx_n;
      shift        <= shift_n;
      r_byte_valid <= byte_valid_n;
      r_frame_err  <= frame_err_n;
      if (byte_valid_n) r_byte <= shift;
    end
  end

  // Bit timer is a down-counter; every sampling point is its terminal count.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    bit_idx_n    = bit_idx;
    shift_n      = shift;
    byte_valid_n = 1'b0;
    frame_err_n  = 1'b0;
    if (state != RX_IDLE && cnt != '0) cnt_n = cnt - 1'b1;
    unique case (state)
      RX_IDLE: begin
        if (!rxd_sync) begin
          state_n = RX_START;
          cnt_n   = HALF_LOAD;
        end
      end
      RX_START: begin
        if (cnt == '0) begin
          if (rxd_sync) begin
            state_n = RX_IDLE;
          end else begin
            state_n   = RX_DATA;
            cnt_n     = BIT_LOAD;
            bit_idx_n = '0;
          end
        end
      end
      RX_DATA: begin
        if (cnt == '0) begin
          shift_n   = {rxd_sync, shift[7:1]};
          cnt_n     = BIT_LOAD;
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt == '0) begin
          state_n      = RX_IDLE;
          byte_valid_n = rxd_sync;
          frame_err_n  = !rxd_sync;
        end
      end
      default: state_n = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/m_imem_loader.sv
// Serial program loader: receives a framed image over UART, writes words to imem,
// and releases processor reset only after a checksum-valid image is complete.
//
// state    | meaning
// S_LEN_HI | waiting for length high byte (after reset)
// S_LEN_LO | waiting for length low byte; length range check
// S_DATA   | assembling big-endian words, writing each on its 4th byte
// S_SUM    | waiting for checksum byte
// S_DONE   | image good, processor released; next byte restarts as LEN_HI
// S_ERR    | frame aborted, processor held; next byte restarts as LEN_HI
module m_imem_loader
  import m_imem_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT   = DEF_CLKS_PER_BIT,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int ADDR_W         = DEF_ADDR_W
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic              w_rxd,
  output logic              r_we,
  output logic [ADDR_W-1:0] r_addr,
  output logic [31:0]       r_data,
  output logic              r_proc_rst,
  output logic              r_done,
  output logic              r_err
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0]      MAX_WORDS = 17'(2 ** ADDR_W);

  logic [7:0]        rx_byte;
  logic              rx_valid, rx_ferr;

  state_t            state, state_n;
  logic [7:0]        len_hi;
  logic [15:0]       words_left;
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        lane;
  logic [23:0]       word_sr;
  logic [7:0]        csum;
  logic [TMO_W-1:0]  tmo_cnt;

  logic [15:0]       len_full;
  logic              len_bad, active, tmo_fire, abort;
  logic              take_len_hi, take_len_lo, take_data, write_word, set_done, set_err;

  m_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .w_clk        (w_clk),
    .w_rst        (w_rst),
    .w_rxd        (w_rxd),
    .r_byte       (rx_byte),
    .r_byte_valid (rx_valid),
    .r_frame_err  (rx_ferr)
  );

  assign len_full = {len_hi, rx_byte};
  assign len_bad  = (len_full == 16'd0) || ({1'b0, len_full} > MAX_WORDS);
  assign active   = (state == S_LEN_LO) || (state == S_DATA) || (state == S_SUM);
  // A byte arriving in the same cycle always wins over the timeout.
  assign tmo_fire = active && !rx_valid && (tmo_cnt == TMO_W'(1));
  assign abort    = rx_ferr || tmo_fire;

  always_comb begin
    state_n     = state;
    take_len_hi = 1'b0;
    take_len_lo = 1'b0;
    take_data   = 1'b0;
    write_word  = 1'b0;
    set_done    = 1'b0;
    set_err     = 1'b0;
    unique case (state)
      S_LEN_HI, S_DONE, S_ERR: begin
        if (rx_valid) begin
          take_len_hi = 1'b1;
          state_n     = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (rx_valid) begin
          if (len_bad) begin
            set_err = 1'b1;
            state_n = S_ERR;
          end else begin
            take_len_lo = 1'b1;
            state_n     = S_DATA;
          end
        end else if (abort) begin
          set_err = 1'b1;
          state_n = S_ERR;
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          take_data = 1'b1;
          if (lane == 2'(WORD_BYTES - 1)) begin
            write_word = 1'b1;
            if (words_left == 16'd1) state_n = S_SUM;
          end
        end else if (abort) begin
          set_err = 1'b1;
          state_n = S_ERR;
        end
      end
      S_SUM: begin
        if (rx_valid) begin
          if (rx_byte == csum) begin
            set_done = 1'b1;
            state_n  = S_DONE;
          end else begin
            set_err = 1'b1;
            state_n = S_ERR;
          end
        end else if (abort) begin
          set_err = 1'b1;
          state_n = S_ERR;
        end
      end
      default: state_n = S_LEN_HI;
    endcase
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state      <= S_LEN_HI;
      len_hi     <= '0;
      words_left <= '0;
      word_idx   <= '0;
      lane       <= '0;
      word_sr    <= '0;
      csum       <= '0;
      tmo_cnt    <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_proc_rst <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      state <= state_n;
      r_we  <= write_word;
      if (rx_valid) tmo_cnt <= TMO_LOAD;
      else if (active && tmo_cnt != '0) tmo_cnt <= tmo_cnt - 1'b1;
      if (take_len_hi) begin
        len_hi     <= rx_byte;
        r_proc_rst <= 1'b1;
        r_done     <= 1'b0;
        r_err      <= 1'b0;
      end
      if (take_len_lo) begin
        words_left <= len_full;
        word_idx   <= '0;
        lane       <= '0;
        csum       <= '0;
      end
      if (take_data) begin
        word_sr <= {word_sr[15:0], rx_byte};
        csum    <= csum + rx_byte;
        lane    <= lane + 2'd1;
      end
      if (write_word) begin
        r_addr     <= word_idx;
        r_data     <= {word_sr, rx_byte};
        word_idx   <= word_idx + 1'b1;
        words_left <= words_left - 16'd1;
      end
      if (set_done) begin
        r_done     <= 1'b1;
        r_proc_rst <= 1'b0;
      end
      if (set_err) begin
        r_err      <= 1'b1;
        r_proc_rst <= 1'b1;
        r_done     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_m_imem_loader.sv
// Directed bench for m_imem_loader: table of whole frames plus hand-written
// sequences for done timing, timeout, framing error, glitch and mid-frame reset.
module tb_m_imem_loader;

  localparam int CPB = 4;
  localparam int TMO = 200;
  localparam int AW  = 12;

  logic          w_clk = 1'b0;
  logic          w_rst = 1'b1;
  logic          w_rxd = 1'b1;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_data;
  logic          r_proc_rst, r_done, r_err;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] we_addr[$];
  logic [31:0]   we_data[$];

  typedef struct {
    logic [0:11][7:0] b;
    int               n;
    int               exp_we;
    logic             exp_done;
    logic             exp_err;
    logic             exp_prst;
    logic [31:0]      w0;
    logic [31:0]      w1;
  } vec_t;

  vec_t vecs[6];

  always #5 w_clk = ~w_clk;

  m_imem_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(TMO), .ADDR_W(AW)) dut (
    .w_clk      (w_clk),
    .w_rst      (w_rst),
    .w_rxd      (w_rxd),
    .r_we       (r_we),
    .r_addr     (r_addr),
    .r_data     (r_data),
    .r_proc_rst (r_proc_rst),
    .r_done     (r_done),
    .r_err      (r_err)
  );

  always @(negedge w_clk) begin
    if (r_we) begin
      we_addr.push_back(r_addr);
      we_data.push_back(r_data);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge w_clk);
    #1;
  endtask

  // Caller is aligned just after a rising edge; each bit is held CPB cycles.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    w_rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      w_rxd = b[i];
      tick(CPB);
    end
    w_rxd = stop;
    tick(CPB);
    w_rxd = 1'b1;
  endtask

  task automatic send_vec(input int v);
    for (int i = 0; i < vecs[v].n; i++) send_byte(vecs[v].b[i], 1'b1);
  endtask

  task automatic check_words(input string tag, input int v);
    chk({tag, " we_count"}, we_addr.size(), vecs[v].exp_we);
    if (vecs[v].exp_we > 0 && we_addr.size() > 0) begin
      chk({tag, " addr0"}, 32'(we_addr[0]), 32'd0);
      chk({tag, " data0"}, we_data[0], vecs[v].w0);
    end
    if (vecs[v].exp_we > 1 && we_addr.size() > 1) begin
      chk({tag, " addr1"}, 32'(we_addr[1]), 32'd1);
      chk({tag, " data1"}, we_data[1], vecs[v].w1);
    end
  endtask

  initial begin
    int first_err;

    // Checksum of 20 08 00 01 44 00 00 00 is 0x6D; DE AD BE EF sums to 0x38.
    vecs[0] = '{b: {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h01, 8'h44, 8'h00, 8'h00, 8'h00, 8'h6D, 8'h00},
                n: 11, exp_we: 2, exp_done: 1'b1, exp_err: 1'b0, exp_prst: 1'b0,
                w0: 32'h20080001, w1: 32'h44000000};
    vecs[1] = '{b: {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h01, 8'h44, 8'h00, 8'h00, 8'h00, 8'h8C, 8'h00},
                n: 11, exp_we: 2, exp_done: 1'b0, exp_err: 1'b1, exp_prst: 1'b1,
                w0: 32'h20080001, w1: 32'h44000000};
    vecs[2] = vecs[0];
    vecs[3] = '{b: {8'h00, 8'h00, 80'h0}, n: 2, exp_we: 0, exp_done: 1'b0, exp_err: 1'b1,
                exp_prst: 1'b1, w0: 32'h0, w1: 32'h0};
    vecs[4] = '{b: {8'h10, 8'h01, 80'h0}, n: 2, exp_we: 0, exp_done: 1'b0, exp_err: 1'b1,
                exp_prst: 1'b1, w0: 32'h0, w1: 32'h0};
    vecs[5] = '{b: {8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h38, 40'h0},
                n: 7, exp_we: 1, exp_done: 1'b1, exp_err: 1'b0, exp_prst: 1'b0,
                w0: 32'hDEADBEEF, w1: 32'h0};

    tick(3);
    chk("reset r_we", r_we, 0);
    chk("reset r_addr", 32'(r_addr), 0);
    chk("reset r_data", r_data, 0);
    chk("reset r_proc_rst", r_proc_rst, 1);
    chk("reset r_done", r_done, 0);
    chk("reset r_err", r_err, 0);
    w_rst = 1'b0;
    tick(5);

    for (int v = 0; v < 6; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      we_addr.delete();
      we_data.delete();
      send_vec(v);
      tick(3);
      check_words(tag, v);
      chk({tag, " r_done"}, r_done, vecs[v].exp_done);
      chk({tag, " r_err"}, r_err, vecs[v].exp_err);
      chk({tag, " r_proc_rst"}, r_proc_rst, vecs[v].exp_prst);
    end

    // Exact timing: restart from S_DONE, then done/release one cycle after SUM byte-valid.
    send_byte(8'h00, 1'b1);
    tick(1);
    chk("restart prst before", r_proc_rst, 0);
    tick(1);
    chk("restart prst", r_proc_rst, 1);
    chk("restart done cleared", r_done, 0);
    send_byte(8'h01, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h56, 1'b1);
    send_byte(8'h78, 1'b1);
    send_byte(8'h14, 1'b1);
    tick(1);
    chk("sum done not early", r_done, 0);
    tick(1);
    chk("sum done", r_done, 1);
    chk("sum prst released", r_proc_rst, 0);

    // Timeout: last byte-valid is one cycle after send returns; r_err rises 200 cycles later.
    we_addr.delete();
    we_data.delete();
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    first_err = -1;
    for (int n = 1; n <= 250; n++) begin
      tick(1);
      if (r_err && first_err < 0) first_err = n;
    end
    chk("timeout cycle", 32'(first_err), 32'd201);
    chk("timeout no write", we_addr.size(), 0);
    chk("timeout prst", r_proc_rst, 1);

    // Framing error on the third data byte.
    we_addr.delete();
    we_data.delete();
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    tick(2);
    chk("ferr err before", r_err, 0);
    send_byte(8'h33, 1'b0);
    tick(3);
    chk("ferr err", r_err, 1);
    chk("ferr no write", we_addr.size(), 0);
    tick(10);

    // Short low glitch on an idle line in S_DONE must not start a byte.
    we_addr.delete();
    we_data.delete();
    send_vec(0);
    tick(3);
    chk("pre-glitch done", r_done, 1);
    w_rxd = 1'b0;
    tick(2);
    w_rxd = 1'b1;
    tick(60);
    chk("glitch done", r_done, 1);
    chk("glitch prst", r_proc_rst, 0);
    chk("glitch err", r_err, 0);
    chk("glitch no write", we_addr.size(), 2);

    // Reset mid-word with a partially received byte on the line.
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h20, 1'b1);
    send_byte(8'h08, 1'b1);
    w_rxd = 1'b0;
    tick(CPB);
    w_rxd = 1'b1;
    tick(CPB);
    w_rxd = 1'b0;
    tick(CPB);
    w_rst = 1'b1;
    w_rxd = 1'b1;
    tick(1);
    chk("rst r_we", r_we, 0);
    chk("rst r_addr", 32'(r_addr), 0);
    chk("rst r_data", r_data, 0);
    chk("rst r_proc_rst", r_proc_rst, 1);
    chk("rst r_done", r_done, 0);
    chk("rst r_err", r_err, 0);
    w_rst = 1'b0;
    tick(20);
    we_addr.delete();
    we_data.delete();
    send_vec(0);
    tick(3);
    check_words("post-rst", 0);
    chk("post-rst done", r_done, 1);
    chk("post-rst err", r_err, 0);
    chk("post-rst prst", r_proc_rst, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
